// File: rtl/sdram_cmd_arbiter_if.sv
// Bundle of requester-side buses and SDRAM pin-side outputs for the command arbiter.
// Latency: none, this is wiring only.
// Backpressure: none, grants are the only flow control (level request, pulse end).
interface sdram_cmd_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DATA_W = 16
);
    // init sequencer
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    // auto-refresh
    logic              aref_req;
    logic              aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    // write burst
    logic              wr_req;
    logic              wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    // read burst
    logic              rd_req;
    logic              rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    // grants and status
    logic              aref_en;
    logic              wr_en;
    logic              rd_en;
    logic              grant_err;
    // SDRAM pins
    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_dq_out;
    logic              sdram_dq_oe;

    // arbiter side
    modport slave (
        input  init_cmd, init_ba, init_addr, init_end,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en, grant_err,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    // requester / pin side
    modport master (
        output init_cmd, init_ba, init_addr, init_end,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en, grant_err,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// Grants the SDRAM command/address/DQ bus to init, refresh, write or read (refresh first, W/R round-robin).
// Latency: grant rises one cycle after the ARBIT decision; one NOP cycle follows every grant.
// Backpressure: requesters hold *_req until granted; a watchdog reclaims a grant never ended.
module sdram_cmd_arbiter #(
    parameter int ADDR_W        = 13,
    parameter int BA_W          = 2,
    parameter int DATA_W        = 16,
    parameter int GRANT_TIMEOUT = 1023
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    sdram_cmd_arbiter_if.slave    bus
);
    localparam int CNT_W = (GRANT_TIMEOUT < 1) ? 1 : $clog2(GRANT_TIMEOUT + 1);
    localparam bit WD_EN = (GRANT_TIMEOUT != 0);
    // Last count value of a grant; the grant is reclaimed when this is reached without an end.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             last_wr_q, last_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_err_q, grant_err_d;
    logic             cke_q;

    logic [3:0]        cmd;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;

    // Next-state, round-robin flag and watchdog counter.
    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        cnt_d       = cnt_q;
        grant_err_d = 1'b0;
        case (state_q)
            S_INIT: begin
                if (bus.init_end) state_d = S_ARBIT;
            end
            S_ARBIT: begin
                // Counter is held at zero here so every grant starts counting from 0.
                cnt_d = '0;
                if (bus.aref_req) begin
                    state_d = S_AREF;
                end else if (bus.wr_req && (!bus.rd_req || !last_wr_q)) begin
                    state_d   = S_WRITE;
                    last_wr_d = 1'b1;
                end else if (bus.rd_req) begin
                    state_d   = S_READ;
                    last_wr_d = 1'b0;
                end
            end
            S_AREF, S_WRITE, S_READ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if ((state_q == S_AREF  && bus.aref_end) ||
                    (state_q == S_WRITE && bus.wr_end)   ||
                    (state_q == S_READ  && bus.rd_end)) begin
                    state_d = S_ARBIT;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    // A same-cycle end takes the branch above, so no error in that case.
                    state_d     = S_ARBIT;
                    grant_err_d = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Control state registers; reset returns the block to INIT from any state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_INIT;
            last_wr_q   <= 1'b0;
            cnt_q       <= '0;
            grant_err_q <= 1'b0;
            cke_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            cnt_q       <= cnt_d;
            grant_err_q <= grant_err_d;
            cke_q       <= 1'b1;
        end
    end

    // Pin mux: init bus in INIT, NOP with all-ones ba/addr in ARBIT, granted requester otherwise.
    always_comb begin
        cmd  = 4'b0111;
        ba   = '1;
        addr = '1;
        case (state_q)
            S_INIT:  begin cmd = bus.init_cmd; ba = bus.init_ba; addr = bus.init_addr; end
            S_AREF:  begin cmd = bus.aref_cmd; ba = bus.aref_ba; addr = bus.aref_addr; end
            S_WRITE: begin cmd = bus.wr_cmd;   ba = bus.wr_ba;   addr = bus.wr_addr;   end
            S_READ:  begin cmd = bus.rd_cmd;   ba = bus.rd_ba;   addr = bus.rd_addr;   end
            default: ;
        endcase
    end

    // Grants are decoded from the state register so they drop as soon as reset asserts.
    assign bus.aref_en      = (state_q == S_AREF);
    assign bus.wr_en        = (state_q == S_WRITE);
    assign bus.rd_en        = (state_q == S_READ);
    assign bus.grant_err    = grant_err_q;
    assign bus.sdram_cke    = cke_q;
    assign bus.sdram_cs_n   = cmd[3];
    assign bus.sdram_ras_n  = cmd[2];
    assign bus.sdram_cas_n  = cmd[1];
    assign bus.sdram_we_n   = cmd[0];
    assign bus.sdram_ba     = ba;
    assign bus.sdram_addr   = addr;
    assign bus.sdram_dq_oe  = (state_q == S_WRITE) && bus.wr_sdram_en;
    assign bus.sdram_dq_out = (state_q == S_WRITE) ? bus.wr_sdram_data : '0;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter with a grant-order scoreboard.
// Latency: checks sampled 2 ns after the rising edge; scoreboard sampled on the falling edge.
// Backpressure: n/a, the bench drives requests and ends directly.
module tb_sdram_cmd_arbiter;
    localparam int AW = 13;
    localparam int BW = 2;
    localparam int DW = 16;
    localparam int TO = 16;

    logic sys_clk;
    logic sys_rst;
    int   tests;
    int   fails;
    byte  exp_q[$];
    logic prev_a, prev_w, prev_r;

    sdram_cmd_arbiter_if #(.ADDR_W(AW), .BA_W(BW), .DATA_W(DW)) bus ();

    sdram_cmd_arbiter #(
        .ADDR_W(AW), .BA_W(BW), .DATA_W(DW), .GRANT_TIMEOUT(TO)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pin_cmd();
        return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
    endfunction

    task automatic chk_nop(input string tag);
        chk({tag, "_cmd"},   pin_cmd(), 4'b0111);
        chk({tag, "_ba"},    bus.sdram_ba, 2'b11);
        chk({tag, "_addr"},  bus.sdram_addr, 13'h1FFF);
        chk({tag, "_grant"}, {bus.aref_en, bus.wr_en, bus.rd_en}, 3'b000);
    endtask

    // Scoreboard: every grant rise or grant_err pulse pops the next expected event.
    always @(negedge sys_clk) begin
        byte got;
        byte exp;
        int  n_rise;
        got    = "-";
        n_rise = 0;
        if (bus.aref_en && !prev_a) begin got = "A"; n_rise++; end
        if (bus.wr_en   && !prev_w) begin got = "W"; n_rise++; end
        if (bus.rd_en   && !prev_r) begin got = "R"; n_rise++; end
        if (n_rise > 1) begin
            tests++;
            fails++;
            $error("FAIL sb_onehot: observed %0d grants rising expected 1", n_rise);
        end else if (n_rise == 1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL sb_grant: observed %s expected no grant", got);
            end else begin
                exp = exp_q.pop_front();
                assert (got === exp) else begin
                    fails++;
                    $error("FAIL sb_grant: observed %s expected %s", got, exp);
                end
            end
        end
        if (bus.grant_err === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL sb_err: observed grant_err expected no event");
            end else begin
                exp = exp_q.pop_front();
                assert (exp === "E") else begin
                    fails++;
                    $error("FAIL sb_err: observed E expected %s", exp);
                end
            end
        end
        prev_a = bus.aref_en;
        prev_w = bus.wr_en;
        prev_r = bus.rd_en;
    end

    initial begin
        tests = 0;
        fails = 0;
        prev_a = 1'b0; prev_w = 1'b0; prev_r = 1'b0;
        sys_rst = 1'b1;
        bus.init_cmd  = 4'b0010; bus.init_ba = 2'b01; bus.init_addr = 13'h0400; bus.init_end = 1'b0;
        bus.aref_req  = 1'b0; bus.aref_end = 1'b0;
        bus.aref_cmd  = 4'b0001; bus.aref_ba = 2'b10; bus.aref_addr = 13'h0AAA;
        bus.wr_req    = 1'b0; bus.wr_end = 1'b0;
        bus.wr_cmd    = 4'b0100; bus.wr_ba = 2'b00; bus.wr_addr = 13'h0123;
        bus.wr_sdram_en = 1'b0; bus.wr_sdram_data = 16'h0000;
        bus.rd_req    = 1'b0; bus.rd_end = 1'b0;
        bus.rd_cmd    = 4'b0101; bus.rd_ba = 2'b11; bus.rd_addr = 13'h0456;

        // Reset state: grants low, cke low, pins follow init bus.
        cyc(3);
        chk("rst_grant", {bus.aref_en, bus.wr_en, bus.rd_en, bus.grant_err}, 4'b0000);
        chk("rst_cke", bus.sdram_cke, 1'b0);
        chk("rst_oe", bus.sdram_dq_oe, 1'b0);
        chk("rst_cmd", pin_cmd(), 4'b0010);
        chk("rst_addr", bus.sdram_addr, 13'h0400);

        // Release reset; cke rises on the first edge, pins keep tracking init.
        sys_rst = 1'b0;
        cyc(1);
        chk("cke_up", bus.sdram_cke, 1'b1);
        bus.init_cmd = 4'b0011; bus.init_ba = 2'b10; bus.init_addr = 13'h0015;
        #1;
        chk("init_cmd", pin_cmd(), 4'b0011);
        chk("init_ba", bus.sdram_ba, 2'b10);
        cyc(3);
        bus.init_end = 1'b1;
        #1;
        chk("init_hold", pin_cmd(), 4'b0011);
        cyc(1);
        chk_nop("arbit0");
        chk("cke_held", bus.sdram_cke, 1'b1);
        bus.init_end = 1'b0;
        cyc(2);
        chk_nop("init_end_fall");

        // All three requests: refresh, then write (last_wr=0), then read.
        bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        exp_q.push_back("A"); exp_q.push_back("W"); exp_q.push_back("R");
        cyc(1);
        chk("aref_en", bus.aref_en, 1'b1);
        chk("aref_cmd", pin_cmd(), 4'b0001);
        chk("aref_addr", bus.sdram_addr, 13'h0AAA);
        bus.aref_req = 1'b0;
        bus.aref_end = 1'b1;
        cyc(1);
        bus.aref_end = 1'b0;
        chk_nop("after_aref");
        cyc(1);
        chk("wr_en", bus.wr_en, 1'b1);
        chk("wr_cmd", pin_cmd(), 4'b0100);
        bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'hA5A5;
        #1;
        chk("wr_dq_oe", bus.sdram_dq_oe, 1'b1);
        chk("wr_dq_out", bus.sdram_dq_out, 16'hA5A5);
        bus.wr_end = 1'b1;
        cyc(1);
        bus.wr_end = 1'b0;
        chk_nop("after_wr");
        chk("arbit_dq_oe", bus.sdram_dq_oe, 1'b0);
        cyc(1);
        chk("rd_en", bus.rd_en, 1'b1);
        chk("rd_ba", bus.sdram_ba, 2'b11);
        chk("rd_dq_oe", bus.sdram_dq_oe, 1'b0);
        chk("rd_dq_out", bus.sdram_dq_out, 16'h0000);
        bus.wr_sdram_en = 1'b0;
        // A write end while reading is ignored.
        bus.wr_end = 1'b1;
        cyc(1);
        bus.wr_end = 1'b0;
        chk("rd_ignore_wr_end", bus.rd_en, 1'b1);
        bus.rd_end = 1'b1;
        cyc(1);
        bus.rd_end = 1'b0;
        chk_nop("after_rd");

        // Continuous W/R requests alternate with one NOP between grants.
        for (int g = 0; g < 4; g++) begin
            exp_q.push_back((g % 2 == 0) ? "W" : "R");
            cyc(1);
            chk("alt_grant", {bus.wr_en, bus.rd_en}, (g % 2 == 0) ? 2'b10 : 2'b01);
            cyc(6);
            chk("alt_hold", {bus.wr_en, bus.rd_en}, (g % 2 == 0) ? 2'b10 : 2'b01);
            if (g % 2 == 0) bus.wr_end = 1'b1; else bus.rd_end = 1'b1;
            cyc(1);
            bus.wr_end = 1'b0; bus.rd_end = 1'b0;
            chk_nop("alt_nop");
        end

        // Refresh raised mid-write waits for wr_end, then wins over a still-pending write.
        bus.rd_req = 1'b0;
        exp_q.push_back("W");
        cyc(1);
        chk("pre_wr_en", bus.wr_en, 1'b1);
        cyc(2);
        bus.aref_req = 1'b1;
        exp_q.push_back("A");
        cyc(4);
        chk("no_preempt", {bus.aref_en, bus.wr_en}, 2'b01);
        bus.wr_end = 1'b1;
        cyc(1);
        bus.wr_end = 1'b0;
        chk_nop("pre_nop");
        cyc(1);
        chk("pre_aref", {bus.aref_en, bus.wr_en}, 2'b10);
        bus.aref_req = 1'b0; bus.wr_req = 1'b0;
        bus.aref_end = 1'b1;
        cyc(1);
        bus.aref_end = 1'b0;
        chk_nop("pre_done");

        // Watchdog: read never ends, grant held TO cycles then reclaimed with one error pulse.
        bus.rd_req = 1'b1;
        exp_q.push_back("R"); exp_q.push_back("E");
        for (int i = 0; i < TO; i++) begin
            cyc(1);
            chk("wd_rd_en", bus.rd_en, 1'b1);
            chk("wd_no_err", bus.grant_err, 1'b0);
        end
        bus.rd_req = 1'b0;
        cyc(1);
        chk_nop("wd_expire");
        chk("wd_err", bus.grant_err, 1'b1);
        cyc(1);
        chk("wd_err_pulse", bus.grant_err, 1'b0);

        // End on the expiry cycle counts as a normal end.
        bus.rd_req = 1'b1;
        exp_q.push_back("R");
        cyc(TO);
        chk("wd_edge_rd_en", bus.rd_en, 1'b1);
        bus.rd_end = 1'b1; bus.rd_req = 1'b0;
        cyc(1);
        bus.rd_end = 1'b0;
        chk_nop("wd_edge_nop");
        chk("wd_edge_no_err", bus.grant_err, 1'b0);
        cyc(1);
        chk("wd_edge_no_err2", bus.grant_err, 1'b0);

        // Reset mid-write drops the grant and cke immediately.
        bus.wr_req = 1'b1;
        exp_q.push_back("W");
        cyc(3);
        chk("mid_wr_en", bus.wr_en, 1'b1);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", bus.wr_en, 1'b0);
        chk("mid_rst_cke", bus.sdram_cke, 1'b0);
        chk("mid_rst_cmd", pin_cmd(), 4'b0011);
        bus.wr_req = 1'b0;
        cyc(2);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish before 200000 ns");
        $fatal(1, "timeout");
    end
endmodule
